pmu_key_loader: RTL and testbench

PMU_KEY_LOADER -- requirements
Module: pmu_key_loader

---
 rtl/pmu_key_loader.sv | 155 +++++++++++++++
 tb/tb_pmu_key_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_key_loader.sv
// Serial-to-parallel AES key loader: shifts in 128 key bits LSB first, writes four
// 32-bit words into the AES core and starts key expansion. Optional WAIT timeout: KEY_LOADER_TIMEOUT_EN.
module pmu_key_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        bit_valid_i,
  input  logic        bit_i,
  input  logic        aes_key_ready_i,
  output logic        aes_reset_n_o,
  output logic        aes_init_o,
  output logic        aes_wc_o,
  output logic        aes_we_o,
  output logic [1:0]  aes_address_o,
  output logic [31:0] aes_write_data_o,
  output logic        busy_o,
  output logic        key_ready_o,
  output logic        error_o
);

`ifdef KEY_LOADER_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, INIT, WAIT, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, INIT, WAIT, DONE} state_t;
`endif

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t        r_state;
  state_t        w_next;
  logic [6:0]    r_cnt;
  logic [1:0]    r_word;
  logic [127:0]  r_key;
  logic          r_aes_rst_n;
  logic          w_key_wipe;

`ifdef KEY_LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // start_i overrides every state, including a same-cycle bit_valid_i
  always_comb begin
    w_next = r_state;
    if (start_i) begin
      w_next = SHIFT;
    end else begin
      case (r_state)
        SHIFT: if (bit_valid_i && (r_cnt == 7'd127)) w_next = WRITE;
        WRITE: if (r_word == 2'd3) w_next = INIT;
        INIT:  w_next = WAIT;
        WAIT: begin
          if (aes_key_ready_i) begin
            w_next = DONE;
          end
`ifdef KEY_LOADER_TIMEOUT_EN
          else if (r_tmo == TMO_LAST) begin
            w_next = ERR;
          end
`endif
        end
        default: w_next = r_state;
      endcase
    end
  end

  // DONE and ERR are only reachable from WAIT, so leaving WAIT without a restart wipes the key
  assign w_key_wipe = (r_state == WAIT) && (w_next != WAIT) && !start_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt       <= '0;
      r_word      <= '0;
      r_key       <= '0;
      r_aes_rst_n <= 1'b0;
    end else begin
      r_aes_rst_n <= ~start_i;
      if (start_i) begin
        r_cnt  <= '0;
        r_word <= '0;
        r_key  <= '0;
      end else begin
        if ((r_state == SHIFT) && bit_valid_i) begin
          r_key[r_cnt] <= bit_i;
          r_cnt        <= r_cnt + 7'd1;
        end
        if (r_state == WRITE) begin
          r_word <= r_word + 2'd1;
        end
        if (w_key_wipe) begin
          r_key <= '0;
        end
      end
    end
  end

`ifdef KEY_LOADER_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tmo <= '0;
    end else if (start_i) begin
      r_tmo <= '0;
    end else if (r_state == WAIT) begin
      r_tmo <= r_tmo + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end
`endif

  always_comb begin
    aes_init_o       = 1'b0;
    aes_wc_o         = 1'b0;
    aes_we_o         = 1'b0;
    aes_address_o    = '0;
    aes_write_data_o = '0;
    busy_o           = 1'b0;
    key_ready_o      = 1'b0;
    error_o          = 1'b0;
    case (r_state)
      SHIFT: busy_o = 1'b1;
      WRITE: begin
        busy_o           = 1'b1;
        aes_we_o         = 1'b1;
        aes_wc_o         = 1'b1;
        aes_address_o    = r_word;
        aes_write_data_o = r_key[{r_word, 5'd0} +: 32];
      end
      INIT: begin
        busy_o     = 1'b1;
        aes_init_o = 1'b1;
      end
      WAIT: busy_o = 1'b1;
      DONE: key_ready_o = 1'b1;
`ifdef KEY_LOADER_TIMEOUT_EN
      ERR:  error_o = 1'b1;
`endif
      default: busy_o = 1'b0;
    endcase
  end

  assign aes_reset_n_o = r_aes_rst_n;

endmodule

// File: tb/tb_pmu_key_loader.sv
// Scoreboard bench for pmu_key_loader: expected AES word writes are queued as
// key bits are driven and checked by a negedge monitor.
module tb_pmu_key_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        bit_valid_i = 1'b0;
  logic        bit_i = 1'b0;
  logic        aes_key_ready_i = 1'b0;
  logic        aes_reset_n_o;
  logic        aes_init_o;
  logic        aes_wc_o;
  logic        aes_we_o;
  logic [1:0]  aes_address_o;
  logic [31:0] aes_write_data_o;
  logic        busy_o;
  logic        key_ready_o;
  logic        error_o;

  int total = 0;
  int bad = 0;
  int init_cnt = 0;
  logic [33:0] exp_q[$];

  localparam logic [127:0] KEY_A = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] KEY_B = 128'h3c5a_9e01_77f0_1234_deadbeef_c0ffee42;

  pmu_key_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .bit_valid_i      (bit_valid_i),
    .bit_i            (bit_i),
    .aes_key_ready_i  (aes_key_ready_i),
    .aes_reset_n_o    (aes_reset_n_o),
    .aes_init_o       (aes_init_o),
    .aes_wc_o         (aes_wc_o),
    .aes_we_o         (aes_we_o),
    .aes_address_o    (aes_address_o),
    .aes_write_data_o (aes_write_data_o),
    .busy_o           (busy_o),
    .key_ready_o      (key_ready_o),
    .error_o          (error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    logic [33:0] e;
    if (aes_we_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", aes_address_o, aes_write_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({aes_address_o, aes_write_data_o} !== e)
          begin bad++; $display("FAIL key_word: got addr=%0d data=%h, expected addr=%0d data=%h", aes_address_o, aes_write_data_o, e[33:32], e[31:0]); end
      end
      total++;
      if (aes_wc_o !== 1'b1) begin bad++; $display("FAIL wc_during_write: got %b expected 1", aes_wc_o); end
    end else begin
      total++;
      if (aes_wc_o !== 1'b0 || aes_address_o !== 2'd0 || aes_write_data_o !== 32'd0) begin
        bad++;
        $display("FAIL idle_bus: got wc=%b addr=%0d data=%h, expected all 0", aes_wc_o, aes_address_o, aes_write_data_o);
      end
    end
    if (aes_init_o === 1'b1) init_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_key(input logic [127:0] k);
    for (int w = 0; w < 4; w++) exp_q.push_back({w[1:0], k[32*w +: 32]});
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    bit_valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    total++;
    if (aes_reset_n_o !== 1'b0 || busy_o !== 1'b1 || key_ready_o !== 1'b0 || error_o !== 1'b0) begin
      bad++;
      $display("FAIL start_state: got rst_n=%b busy=%b kr=%b err=%b, expected 0 1 0 0", aes_reset_n_o, busy_o, key_ready_o, error_o);
    end
    tick();
    total++;
    if (aes_reset_n_o !== 1'b1) begin bad++; $display("FAIL aes_reset_pulse_width: got %b expected 1", aes_reset_n_o); end
  endtask

  task automatic send_bits(input logic [127:0] k, input int n, input bit gaps);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && (c % 3 == 2)) begin
        bit_valid_i = 1'b0;
        bit_i = ~k[i];
        tick();
        c++;
      end
      bit_valid_i = 1'b1;
      bit_i = k[i];
      tick();
      c++;
    end
    bit_valid_i = 1'b0;
  endtask

  // entered one cycle after the final bit was accepted (first WRITE cycle)
  task automatic finish_load(input int delay);
    int i0 = init_cnt;
    repeat (4) tick();
    total++;
    if (aes_init_o !== 1'b1 || aes_we_o !== 1'b0) begin bad++; $display("FAIL init_timing: got init=%b we=%b expected 1 0", aes_init_o, aes_we_o); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL writes_pending: got %0d left expected 0", exp_q.size()); end
    tick();
    total++;
    if (aes_init_o !== 1'b0 || busy_o !== 1'b1 || key_ready_o !== 1'b0) begin
      bad++; $display("FAIL wait_state: got init=%b busy=%b kr=%b expected 0 1 0", aes_init_o, busy_o, key_ready_o);
    end
    repeat (delay) tick();
    aes_key_ready_i = 1'b1;
    tick();
    aes_key_ready_i = 1'b0;
    total++;
    if (key_ready_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL done_state: got kr=%b busy=%b expected 1 0", key_ready_o, busy_o); end
    tick();
    total++;
    if (key_ready_o !== 1'b1) begin bad++; $display("FAIL key_ready_hold: got %b expected 1", key_ready_o); end
    total++;
    if (init_cnt - i0 != 1) begin bad++; $display("FAIL init_pulse_count: got %0d expected 1", init_cnt - i0); end
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b0;
    #1;
    total++;
    if ({aes_reset_n_o, aes_init_o, aes_wc_o, aes_we_o, aes_address_o, aes_write_data_o, busy_o, key_ready_o, error_o} !== '0) begin
      bad++; $display("FAIL reset_outputs: got rst_n=%b we=%b busy=%b kr=%b err=%b expected all 0", aes_reset_n_o, aes_we_o, busy_o, key_ready_o, error_o);
    end
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
    total++;
    if (aes_reset_n_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL post_reset: got rst_n=%b busy=%b expected 1 0", aes_reset_n_o, busy_o); end
  endtask

  task automatic test_basic_load();
    start_pulse();
    send_bits(KEY_A, 128, 1'b0);
    exp_q.push_back({2'd0, 32'h89abcdef});
    exp_q.push_back({2'd1, 32'h01234567});
    exp_q.push_back({2'd2, 32'h89abcdef});
    exp_q.push_back({2'd3, 32'h01234567});
    finish_load(3);
  endtask

  task automatic test_gapped_bits();
    start_pulse();
    total++;
    if (key_ready_o !== 1'b0) begin bad++; $display("FAIL restart_clears_ready: got %b expected 0", key_ready_o); end
    send_bits(KEY_A, 128, 1'b1);
    exp_q.push_back({2'd0, 32'h89abcdef});
    exp_q.push_back({2'd1, 32'h01234567});
    exp_q.push_back({2'd2, 32'h89abcdef});
    exp_q.push_back({2'd3, 32'h01234567});
    finish_load(0);
  endtask

  task automatic test_abort();
    start_pulse();
    send_bits(KEY_B, 64, 1'b0);
    start_pulse();
    send_bits('1, 128, 1'b0);
    for (int w = 0; w < 4; w++) exp_q.push_back({w[1:0], 32'hffffffff});
    finish_load(5);
  endtask

  task automatic test_same_cycle();
    start_pulse();
    send_bits(KEY_B, 10, 1'b0);
    start_i = 1'b1;
    bit_valid_i = 1'b1;
    bit_i = 1'b1;
    tick();
    start_i = 1'b0;
    bit_valid_i = 1'b0;
    total++;
    if (aes_reset_n_o !== 1'b0) begin bad++; $display("FAIL same_cycle_restart: got rst_n=%b expected 0", aes_reset_n_o); end
    send_bits(KEY_B, 128, 1'b0);
    push_key(KEY_B);
    finish_load(1);
  endtask

  task automatic test_reset_mid_write();
    start_pulse();
    send_bits(KEY_B, 128, 1'b0);
    push_key(KEY_B);
    @(negedge clk_i);
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    total++;
    if ({aes_reset_n_o, aes_init_o, aes_wc_o, aes_we_o, aes_address_o, aes_write_data_o, busy_o, key_ready_o, error_o} !== '0) begin
      bad++; $display("FAIL reset_mid_write: got we=%b addr=%0d data=%h busy=%b expected all 0", aes_we_o, aes_address_o, aes_write_data_o, busy_o);
    end
    total++;
    if (exp_q.size() != 2) begin bad++; $display("FAIL words_before_reset: got %0d left expected 2", exp_q.size()); end
    exp_q.delete();
    tick();
    rst_i = 1'b1;
    repeat (12) tick();
    total++;
    if (busy_o !== 1'b0 || aes_reset_n_o !== 1'b1 || key_ready_o !== 1'b0) begin
      bad++; $display("FAIL after_mid_reset: got busy=%b rst_n=%b kr=%b expected 0 1 0", busy_o, aes_reset_n_o, key_ready_o);
    end
  endtask

`ifdef KEY_LOADER_TIMEOUT_EN
  task automatic test_wait_policy();
    start_pulse();
    send_bits(KEY_A, 128, 1'b0);
    push_key(KEY_A);
    repeat (5) tick();
    repeat (15) tick();
    total++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL timeout_early: got err=%b busy=%b expected 0 1", error_o, busy_o); end
    tick();
    total++;
    if (error_o !== 1'b1 || key_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL timeout_error: got err=%b kr=%b busy=%b expected 1 0 0", error_o, key_ready_o, busy_o);
    end
    aes_key_ready_i = 1'b1;
    repeat (3) tick();
    aes_key_ready_i = 1'b0;
    total++;
    if (error_o !== 1'b1 || key_ready_o !== 1'b0) begin bad++; $display("FAIL error_hold: got err=%b kr=%b expected 1 0", error_o, key_ready_o); end
    start_pulse();
    send_bits(KEY_A, 128, 1'b0);
    push_key(KEY_A);
    finish_load(2);
  endtask
`else
  task automatic test_wait_policy();
    start_pulse();
    send_bits(KEY_A, 128, 1'b0);
    push_key(KEY_A);
    repeat (5) tick();
    repeat (40) tick();
    total++;
    if (error_o !== 1'b0 || busy_o !== 1'b1 || key_ready_o !== 1'b0) begin
      bad++; $display("FAIL wait_indefinite: got err=%b busy=%b kr=%b expected 0 1 0", error_o, busy_o, key_ready_o);
    end
    aes_key_ready_i = 1'b1;
    tick();
    aes_key_ready_i = 1'b0;
    total++;
    if (key_ready_o !== 1'b1) begin bad++; $display("FAIL late_ready: got %b expected 1", key_ready_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_gapped_bits();
    test_abort();
    test_same_cycle();
    test_reset_mid_write();
    test_wait_policy();
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
